// File: rtl/axi4_rd_burst_master.sv
// rtl/axi4_rd_burst_master.sv - AXI4 INCR read initiator streaming a linear region into a FWFT FIFO
// One burst in flight; AR issue waits until the FIFO can absorb the whole burst.
module axi4_rd_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int ARID_VAL   = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [15:0]           total_beats_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  fifo_valid_o,
  output logic [DATA_WIDTH-1:0] fifo_data_o,
  input  logic                  fifo_ready_i
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA, FIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [15:0]           remain_q, remain_d;
  logic [15:0]           burst_n_q, burst_n_d;
  logic [15:0]           beat_cnt_q, beat_cnt_d;
  logic [15:0]           reserved_q, reserved_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [12:0] to_4k_bytes;
  logic [12:0] to_4k_beats;
  logic [15:0] n;
  logic [17:0] need;
  logic        credit_ok;
  logic        ar_hs;
  logic        r_hs;
  logic        pop;
  logic        push_en;
  logic        last_beat;
  logic        unused_rid;

  assign unused_rid = ^rid;

  // Burst size: limited by remaining beats, BURST_LEN and the next 4 KB page edge.
  always_comb begin
    to_4k_bytes = 13'h1000 - {1'b0, cur_addr_q[11:0]};
    to_4k_beats = to_4k_bytes >> BSH;
    n = remain_q;
    if (n > 16'(BURST_LEN)) n = 16'(BURST_LEN);
    if (n > {3'b000, to_4k_beats}) n = {3'b000, to_4k_beats};
    need      = 18'(occ_q) + 18'(reserved_q) + 18'(n);
    credit_ok = (need <= 18'(FIFO_DEPTH));
  end

  assign arid    = ID_WIDTH'(ARID_VAL);
  assign arsize  = 3'(BSH);
  assign arburst = 2'b01;
  assign araddr  = cur_addr_q;
  assign arlen   = (state_q == REQ) ? 8'(n - 16'd1) : 8'd0;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  assign busy_o = (state_q == REQ) || (state_q == DATA);
  assign done_o = (state_q == FIN);
  assign err_o  = err_q;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    burst_n_d  = burst_n_q;
    beat_cnt_d = beat_cnt_q;
    reserved_d = reserved_q;
    err_d      = err_q;
    arvalid    = 1'b0;
    rready     = 1'b0;
    last_beat  = 1'b0;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start_i) begin
          cur_addr_d = base_addr_i & ~ADDR_WIDTH'(BYTES - 1);
          remain_d   = total_beats_i;
          beat_cnt_d = 16'd0;
          reserved_d = 16'd0;
          err_d      = 1'b0;
          state_d    = (total_beats_i == 16'd0) ? FIN : REQ;
        end
      end
      REQ: begin
        // Occupancy only falls while here, so arvalid never drops before the handshake.
        arvalid = credit_ok;
        if (ar_hs) begin
          burst_n_d  = n;
          reserved_d = n;
          beat_cnt_d = 16'd0;
          state_d    = DATA;
        end
      end
      DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          last_beat  = (beat_cnt_q + 16'd1 == burst_n_q);
          beat_cnt_d = beat_cnt_q + 16'd1;
          reserved_d = reserved_q - 16'd1;
          if (rresp != 2'b00) err_d = 1'b1;
          if (rlast != last_beat) err_d = 1'b1;
          if (rlast || last_beat) begin
            reserved_d = 16'd0;
            cur_addr_d = cur_addr_q + (ADDR_WIDTH'(burst_n_q) << BSH);
            remain_d   = remain_q - burst_n_q;
            state_d    = (remain_q == burst_n_q) ? FIN : REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop          = (occ_q != '0) && fifo_ready_i;
  assign push_en      = r_hs && ((occ_q != CNT_W'(FIFO_DEPTH)) || pop);
  assign fifo_valid_o = (occ_q != '0);
  assign fifo_data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d    = occ_q + CNT_W'(push_en) - CNT_W'(pop);
  end

  always_ff @(posedge aclk) begin
    if (push_en) mem_q[wr_ptr_q] <= rdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      burst_n_q  <= '0;
      beat_cnt_q <= '0;
      reserved_q <= '0;
      err_q      <= 1'b0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      burst_n_q  <= burst_n_d;
      beat_cnt_q <= beat_cnt_d;
      reserved_q <= reserved_d;
      err_q      <= err_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_axi4_rd_burst_master.sv
// tb/tb_axi4_rd_burst_master.sv - bench for axi4_rd_burst_master with a behavioural AXI4 memory responder
module tb_axi4_rd_burst_master;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic        aclk;
  logic        aresetn;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [15:0] total_beats_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        fifo_valid_o;
  logic [63:0] fifo_data_o;
  logic        fifo_ready_i;

  axi4_rd_burst_master dut (
    .aclk(aclk), .aresetn(aresetn), .start_i(start_i), .base_addr_i(base_addr_i),
    .total_beats_i(total_beats_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .fifo_valid_o(fifo_valid_o),
    .fifo_data_o(fifo_data_o), .fifo_ready_i(fifo_ready_i)
  );

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int push_cnt = 0;
  int bench_occ = 0;
  int gbeat = 0;
  int err_beat = -1;
  int pop_budget = 0;
  int pop_mode = 1;
  bit no_rlast = 0;
  ar_t r_q[$];
  ar_t ar_log[$];
  logic [63:0] pop_log[$];

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {~a, a};
  endfunction

  // Responder + monitor: observe at negedge, drive after posedge.
  task automatic bus_loop();
    bit  ar_fire, r_fire, pop_fire, prev_stall;
    ar_t prev_ar;
    int  rb_idx;
    prev_stall = 0;
    rb_idx = 0;
    forever begin
      @(negedge aclk);
      ar_fire = 0;
      r_fire = 0;
      pop_fire = 0;
      if (!aresetn) begin
        r_q.delete();
        rb_idx = 0;
        prev_stall = 0;
        bench_occ = 0;
        arready = 0;
        rvalid = 0;
        rlast = 0;
      end else begin
        ar_fire  = arvalid && arready;
        r_fire   = rvalid && rready;
        pop_fire = fifo_valid_o && fifo_ready_i;
        if (prev_stall) begin
          n_checks++;
          if (!arvalid || araddr !== prev_ar.addr || arlen !== prev_ar.len) begin
            n_fail++;
            $display("FAIL ar_stable: arvalid=%0b araddr=%h arlen=%0d required held araddr=%h arlen=%0d",
                     arvalid, araddr, arlen, prev_ar.addr, prev_ar.len);
          end
        end
        prev_stall = arvalid && !arready;
        prev_ar = '{addr: araddr, len: arlen};
        if (ar_fire) begin
          ar_log.push_back('{addr: araddr, len: arlen});
          r_q.push_back('{addr: araddr, len: arlen});
          n_checks++;
          if (arsize !== 3'd3 || arburst !== 2'b01 || arid !== 4'd0) begin
            n_fail++;
            $display("FAIL ar_fields: arsize=%0d arburst=%0d arid=%0d required 3/1/0", arsize, arburst, arid);
          end
        end
        if (pop_fire) begin
          pop_log.push_back(fifo_data_o);
          if (pop_budget > 0) pop_budget--;
        end
        if (r_fire) push_cnt++;
        bench_occ = bench_occ + int'(r_fire) - int'(pop_fire);
        if (r_fire) begin
          n_checks++;
          if (bench_occ > 64) begin
            n_fail++;
            $display("FAIL fifo_overflow: occupancy=%0d required <=64", bench_occ);
          end
        end
        if (done_o) done_cnt++;
      end
      @(posedge aclk);
      #1;
      if (aresetn) begin
        if (r_fire && r_q.size() > 0) begin
          rb_idx++;
          gbeat++;
          if (rb_idx == int'(r_q[0].len) + 1) begin
            void'(r_q.pop_front());
            rb_idx = 0;
          end
          rvalid = 0;
        end
        if (!rvalid && r_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          rvalid = 1;
          rdata  = mem_word(r_q[0].addr + 32'(rb_idx * 8));
          rlast  = (rb_idx == int'(r_q[0].len)) && !no_rlast;
          rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
        end
        arready = 1'($urandom_range(0, 1));
        case (pop_mode)
          0:       fifo_ready_i = 0;
          1:       fifo_ready_i = 1;
          2:       fifo_ready_i = 1'($urandom_range(0, 1));
          default: fifo_ready_i = (pop_budget > 0);
        endcase
      end
    end
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] total);
    @(posedge aclk);
    #1;
    base_addr_i = base;
    total_beats_i = total;
    start_i = 1;
    @(posedge aclk);
    #1;
    start_i = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge aclk);
      if (done_cnt > 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge aclk);
    n_checks++;
    if ({arvalid, rready, busy_o, done_o, err_o, fifo_valid_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: arvalid/rready/busy/done/err/fifo_valid=%b required 000000",
               {arvalid, rready, busy_o, done_o, err_o, fifo_valid_o});
    end
    n_checks++;
    if (araddr !== 32'd0 || arlen !== 8'd0 || arsize !== 3'd3 || arburst !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_ar: araddr=%h arlen=%0d arsize=%0d arburst=%0d required 0/0/3/1",
               araddr, arlen, arsize, arburst);
    end
  endtask

  task automatic test_linear(input string name, input logic [31:0] base, input int total, input int mode);
    ar_t exp_ar[$];
    logic [31:0] a;
    int rem, n, to4k, bad, first_bad;
    bit ok;
    ar_log.delete();
    pop_log.delete();
    done_cnt = 0;
    gbeat = 0;
    pop_mode = mode;
    a = base & ~32'h7;
    rem = total;
    while (rem > 0) begin
      to4k = (4096 - int'(a[11:0])) / 8;
      n = rem;
      if (n > 16) n = 16;
      if (n > to4k) n = to4k;
      exp_ar.push_back('{addr: a, len: 8'(n - 1)});
      a = a + 32'(n * 8);
      rem -= n;
    end
    do_start(base, 16'(total));
    wait_done(5000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s done_timeout: done_o seen=%0d required 1", name, done_cnt);
    end
    pop_mode = 1;
    for (int i = 0; i < 300 && pop_log.size() < total; i++) @(posedge aclk);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if (ar_log.size() != exp_ar.size()) begin
      n_fail++;
      $display("FAIL %s ar_count: got %0d required %0d", name, ar_log.size(), exp_ar.size());
    end else begin
      foreach (exp_ar[i]) begin
        n_checks++;
        if (ar_log[i] !== exp_ar[i]) begin
          n_fail++;
          $display("FAIL %s ar[%0d]: araddr=%h arlen=%0d required araddr=%h arlen=%0d",
                   name, i, ar_log[i].addr, ar_log[i].len, exp_ar[i].addr, exp_ar[i].len);
        end
      end
    end
    n_checks++;
    if (pop_log.size() != total) begin
      n_fail++;
      $display("FAIL %s word_count: got %0d required %0d", name, pop_log.size(), total);
    end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < pop_log.size() && i < total; i++) begin
      if (pop_log[i] !== mem_word((base & ~32'h7) + 32'(i * 8))) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s words: %0d wrong, first at %0d got %h required %h", name, bad, first_bad,
               pop_log[first_bad], mem_word((base & ~32'h7) + 32'(first_bad * 8)));
    end
    n_checks++;
    if (done_cnt != 1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: done count=%0d busy=%0b required 1/0", name, done_cnt, busy_o);
    end
  endtask

  task automatic test_basic();
    test_linear("t1_single", 32'h8000_0000, 16, 1);
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL t1 err: err_o=%0b required 0", err_o);
    end
    test_linear("t2_multi", 32'h8000_0000, 40, 1);
  endtask

  task automatic test_4k_boundary();
    test_linear("t3_4k", 32'h8000_0FC0, 16, 2);
    n_checks++;
    if (ar_log.size() != 2 || ar_log[0].len !== 8'd7 || ar_log[1].addr !== 32'h8000_1000 ||
        ar_log[1].len !== 8'd7) begin
      n_fail++;
      $display("FAIL t3_split: count=%0d required 2 bursts len 7 @80000FC0 and len 7 @80001000", ar_log.size());
    end
    test_linear("wrap", 32'hFFFF_FFC0, 20, 1);
  endtask

  task automatic test_credit();
    bit ok;
    ar_log.delete();
    pop_log.delete();
    done_cnt = 0;
    push_cnt = 0;
    gbeat = 0;
    pop_budget = 0;
    pop_mode = 0;
    do_start(32'h8000_2000, 16'd128);
    repeat (300) @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if (push_cnt != 64 || ar_log.size() != 4) begin
      n_fail++;
      $display("FAIL t4_fill: buffered=%0d ARs=%0d required 64/4", push_cnt, ar_log.size());
    end
    n_checks++;
    if (fifo_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_state: fifo_valid=%0b busy=%0b required 1/1", fifo_valid_o, busy_o);
    end
    pop_budget = 15;
    pop_mode = 3;
    repeat (60) @(posedge aclk);
    n_checks++;
    if (pop_log.size() != 15 || ar_log.size() != 4) begin
      n_fail++;
      $display("FAIL t4_15free: pops=%0d ARs=%0d required 15/4", pop_log.size(), ar_log.size());
    end
    pop_budget = 1;
    repeat (40) @(posedge aclk);
    n_checks++;
    if (ar_log.size() != 5) begin
      n_fail++;
      $display("FAIL t4_16free: ARs=%0d required 5", ar_log.size());
    end
    pop_mode = 1;
    wait_done(3000, ok);
    for (int i = 0; i < 300 && pop_log.size() < 128; i++) @(posedge aclk);
    n_checks++;
    if (!ok || pop_log.size() != 128 || ar_log.size() != 8) begin
      n_fail++;
      $display("FAIL t4_finish: done=%0b words=%0d ARs=%0d required 1/128/8", ok, pop_log.size(), ar_log.size());
    end
    for (int i = 0; i < pop_log.size(); i++) begin
      n_checks++;
      if (pop_log[i] !== mem_word(32'h8000_2000 + 32'(i * 8))) begin
        n_fail++;
        $display("FAIL t4_word[%0d]: got %h required %h", i, pop_log[i], mem_word(32'h8000_2000 + 32'(i * 8)));
        break;
      end
    end
  endtask

  task automatic test_slverr();
    bit ok;
    err_beat = 3;
    test_linear("t5_slverr", 32'h8000_4000, 16, 1);
    err_beat = -1;
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_err: err_o=%0b required 1", err_o);
    end
    repeat (10) @(posedge aclk);
    @(negedge aclk);
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_sticky: err_o=%0b required 1", err_o);
    end
    done_cnt = 0;
    do_start(32'h8000_4100, 16'd4);
    @(negedge aclk);
    n_checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_clear: err_o=%0b busy=%0b required 0/1", err_o, busy_o);
    end
    wait_done(1000, ok);
    @(negedge aclk);
    n_checks++;
    if (!ok || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_clean: done=%0b err_o=%0b required 1/0", ok, err_o);
    end
  endtask

  task automatic test_missing_rlast();
    no_rlast = 1;
    test_linear("rlast_missing", 32'h8000_5000, 16, 1);
    no_rlast = 0;
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rlast_err: err_o=%0b required 1", err_o);
    end
  endtask

  task automatic test_reset_midburst();
    int i;
    pop_mode = 1;
    push_cnt = 0;
    do_start(32'h8000_6000, 16'd40);
    for (i = 0; i < 500 && push_cnt < 5; i++) @(posedge aclk);
    n_checks++;
    if (push_cnt < 5) begin
      n_fail++;
      $display("FAIL t6_progress: beats=%0d required >=5", push_cnt);
    end
    @(posedge aclk);
    #1;
    aresetn = 0;
    #1;
    n_checks++;
    if ({arvalid, rready, busy_o, done_o, err_o, fifo_valid_o} !== 6'b0 || araddr !== 32'd0 ||
        arlen !== 8'd0 || arsize !== 3'd3 || arburst !== 2'b01) begin
      n_fail++;
      $display("FAIL t6_reset: ctrl=%b araddr=%h arlen=%0d arsize=%0d arburst=%0d required 000000/0/0/3/1",
               {arvalid, rready, busy_o, done_o, err_o, fifo_valid_o}, araddr, arlen, arsize, arburst);
    end
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1;
    ar_log.delete();
    done_cnt = 0;
    do_start(32'h1234_5678, 16'd0);
    @(negedge aclk);
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_zero_done: done_o=%0b busy=%0b required 1/0", done_o, busy_o);
    end
    @(negedge aclk);
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_zero_pulse: done_o=%0b required 0", done_o);
    end
    repeat (10) @(posedge aclk);
    n_checks++;
    if (ar_log.size() != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL t6_zero_ar: ARs=%0d dones=%0d required 0/1", ar_log.size(), done_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] base;
    for (int k = 0; k < 6; k++) begin
      base = $urandom;
      if ($urandom_range(0, 1) == 1) base[11:0] = 12'hF00 + 12'($urandom_range(0, 31) * 8);
      test_linear($sformatf("rand%0d", k), base, $urandom_range(1, 70), $urandom_range(1, 2));
    end
  endtask

  initial begin
    aresetn = 0;
    start_i = 0;
    base_addr_i = 0;
    total_beats_i = 0;
    arready = 0;
    rid = 0;
    rdata = 0;
    rresp = 0;
    rlast = 0;
    rvalid = 0;
    fifo_ready_i = 0;
    fork
      bus_loop();
    join_none
    repeat (3) @(posedge aclk);
    test_reset();
    @(posedge aclk);
    #1;
    aresetn = 1;
    test_basic();
    test_4k_boundary();
    test_credit();
    test_slverr();
    test_missing_rlast();
    test_reset_midburst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
